timer_unit: RTL and testbench
=============================

# timer_unit

Programmable timer that consumes the divided clock from the clock pre-scaler and turns it into counting, compare-match and overflow events for the CPU. Runs entirely on the system clock. The pre-scaler output enters as a data input `tick_in`, is synchronised and rising-edge detected, and each detected edge advances a WIDTH-bit counter. A small register interface lets the CPU configure the block and poll it. A level interrupt is raised on compare match.

## Interface
- `WIDTH`, 16, counter/compare width; legal range 8–32.
- `SYNC_STAGES`, 2, synchroniser depth for `tick_in`; must be ≥2.

- `clk_in`  in  1  system clock; all logic is on its rising edge.
- `reset_n`  in  1  reset; one clock, reset is synchronous and active-low.
- `tick_in`  in  1  divided clock from the pre-scaler, treated as asynchronous data.
- `wr_en`  in  1  register write strobe.
- `rd_en`  in  1  register read strobe.
- `addr`  in  2  register select: 0 CTRL, 1 COMPARE, 2 COUNT, 3 STATUS.
- `wr_data`  in  WIDTH  write data.
- `rd_data`  out  WIDTH  read data, registered.
- `irq`  out  1  interrupt, level.

## Operation
- CTRL bits: [0] `enable`, [1] `auto_reload`, [2] `irq_en`. Other bits write-ignored and read 0.
- STATUS bits: [0] `match`, [1] `ovf`. Both are sticky. Writing 1 to a bit clears it; writing 0 has no effect.
- COMPARE is read/write. A write to COUNT loads the counter directly.
- `tick_pulse` = synchronised `tick_in` high while its previous sample was low. It is one cycle wide, once per pre-scaler period.
- FSM states:
  - IDLE: `enable`=0.
  - RUN: `enable`=1.
  - DONE: one-shot finished.
- FSM transitions:
  - IDLE→RUN on a CTRL write with `enable`=1.
  - Any state→IDLE on a CTRL write with `enable`=0.
  - RUN→DONE on a match when `auto_reload`=0; hardware then clears `enable`.
  - DONE→RUN on a CTRL write with `enable`=1.
- Counting happens only in RUN with `tick_pulse`=1:
  - count == COMPARE, auto-reload: count←0 and set `match`.
  - count == COMPARE, one-shot: count holds and set `match`.
  - count == all-ones, not equal to COMPARE: count wraps to 0 and set `ovf`.
  - otherwise: count←count+1.
- COMPARE=0 in auto-reload: every tick matches and count stays 0.
- A COUNT load above COMPARE runs up to all-ones, wraps with `ovf`, then matches on the following pass.
- `irq` = `match` & `irq_en`, decoded from registered flags. No pulse stretching.
- Read decode:
  - `rd_data` is updated only on `rd_en`; otherwise it holds.
  - Reads of CTRL/STATUS are zero-extended to WIDTH.
  - Reads have no side effects.

## Timing
- Reset values (on the edge where `reset_n`=0): state IDLE; CTRL, COMPARE, COUNT, STATUS, `rd_data` all 0; `irq`=0; synchroniser and edge history 0.
- Reset mid-count aborts immediately. No tick is counted on the reset edge or the first edge after reset release.
- Latency from `tick_in` to counter:
  - edge k: `tick_in` first sampled high.
  - edge k+SYNC_STAGES: `tick_pulse`=1.
  - edge k+SYNC_STAGES+1: count updated (3 cycles at default).
- Register writes take effect on the edge where `wr_en` is sampled.
- Read latency is 1 cycle: `rd_data` is valid after the edge sampling `rd_en`.
- `irq` follows `match` with 0 extra cycles.
- Simultaneous events:
  - COUNT write and counting tick in the same cycle: the write wins and the tick is lost.
  - STATUS clear and new match/ovf set in the same cycle: set wins.
  - CTRL `enable`=0 write and match in the same cycle: the write wins, with no match and no count change.
  - `wr_en` and `rd_en` on the same address in the same cycle: the read returns the pre-write value.
- `tick_in` high/low phases must each span ≥2 `clk_in` cycles; faster inputs may drop ticks.

## Structure
- Package `timer_pkg`:
  - address localparams `ADDR_CTRL`, `ADDR_COMPARE`, `ADDR_COUNT`, `ADDR_STATUS`.
  - CTRL/STATUS bit indices.
  - FSM state encoding `ST_IDLE`, `ST_RUN`, `ST_DONE`.
- Sub-module `tick_sync`:
  - parameterised `SYNC_STAGES` flop chain plus previous-sample flop.
  - outputs `tick_pulse`.
  - reused by any future pre-scaler consumer.
- Top level: register file, FSM, counter datapath, read mux.

## Test plan
- Reset, then read all four addresses → all read 0 and `irq`=0.
- COMPARE=3, CTRL=0b111, pre-scaler divide-by-4 drives `tick_in` → COUNT sequence 1,2,3,0,1…; `match` and `irq` rise 3 cycles after the 4th `tick_in` rise.
- One-shot: CTRL=0b101, COMPARE=2 → count stops at 2, state DONE, CTRL reads 0b100, `irq`=1. Write STATUS=1 → `irq`=0.
- WIDTH=8, COMPARE=5, load COUNT=0xFE, run → COUNT reaches 0xFF then 0x00 with `ovf`=1, then 1…5 with `match`=1.
- Same-cycle boundary cases:
  - COUNT write of 0x10 on the `tick_pulse` cycle → COUNT=0x10.
  - STATUS clear on the match cycle → `match` stays 1.
- Assert `reset_n`=0 for one cycle mid-count with count=7 → next cycle everything is 0 and the block is in IDLE. A `tick_in` edge one edge later is ignored.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timer: register map, CTRL/STATUS bit positions,
// FSM encoding and the per-tick counter event classification.
package timer_pkg;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_COMPARE = 2'd1;
    localparam logic [1:0] ADDR_COUNT   = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam int CTRL_ENABLE      = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;
    localparam int CTRL_BITS        = 3;

    localparam int STAT_MATCH = 0;
    localparam int STAT_OVF   = 1;
    localparam int STAT_BITS  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } timer_state_e;

    typedef enum logic [1:0] {
        EV_NONE  = 2'd0,
        EV_INC   = 2'd1,
        EV_MATCH = 2'd2,
        EV_WRAP  = 2'd3
    } count_event_e;

    // Compare match outranks wrap: a count of all-ones equal to COMPARE is a match.
    function automatic count_event_e classify_tick(input logic is_match, input logic is_max);
        if (is_match) begin
            return EV_MATCH;
        end else if (is_max) begin
            return EV_WRAP;
        end
        return EV_INC;
    endfunction

endpackage

// File: rtl/tick_sync.sv
// Synchroniser plus rising-edge detector for an asynchronous divided clock;
// emits a registered one-cycle tick_pulse per rising edge of tick_in.
module tick_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic reset_n,
    input  logic tick_in,
    output logic tick_pulse
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   pulse_q, pulse_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], tick_in};
        prev_d  = sync_q[SYNC_STAGES-1];
        pulse_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign tick_pulse = pulse_q;

endmodule

// File: rtl/timer_unit.sv
// Programmable timer: counts synchronised pre-scaler ticks, raises compare-match
// and overflow flags, and exposes CTRL/COMPARE/COUNT/STATUS through a register port.
module timer_unit
    import timer_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             tick_in,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             irq
);

    timer_state_e         state_q, state_d;
    logic [CTRL_BITS-1:0] ctrl_q, ctrl_d;
    logic [WIDTH-1:0]     compare_q, compare_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic [STAT_BITS-1:0] status_q, status_d;
    logic [WIDTH-1:0]     rd_data_q, rd_data_d;

    logic         tick_pulse;
    logic         wr_ctrl, wr_compare, wr_count, wr_status;
    logic         stop_wr;
    logic         count_tick;
    count_event_e tick_event;

    tick_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_tick_sync (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .tick_in   (tick_in),
        .tick_pulse(tick_pulse)
    );

    assign wr_ctrl    = wr_en && (addr == ADDR_CTRL);
    assign wr_compare = wr_en && (addr == ADDR_COMPARE);
    assign wr_count   = wr_en && (addr == ADDR_COUNT);
    assign wr_status  = wr_en && (addr == ADDR_STATUS);
    assign stop_wr    = wr_ctrl && !wr_data[CTRL_ENABLE];

    // A COUNT load or a disabling CTRL write swallows a coincident tick entirely.
    assign count_tick = (state_q == ST_RUN) && tick_pulse && !wr_count && !stop_wr;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        tick_event = EV_NONE;
        if (count_tick) begin
            tick_event = classify_tick(count_q == compare_q, count_q == {WIDTH{1'b1}});
        end
    end

    always_comb begin
        state_d = state_q;
        if (wr_ctrl) begin
            state_d = wr_data[CTRL_ENABLE] ? ST_RUN : ST_IDLE;
        end else if (tick_event == EV_MATCH && !ctrl_q[CTRL_AUTO_RELOAD]) begin
            state_d = ST_DONE;
        end
    end

    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_ctrl) begin
            ctrl_d = wr_data[CTRL_BITS-1:0];
        end else if (tick_event == EV_MATCH && !ctrl_q[CTRL_AUTO_RELOAD]) begin
            ctrl_d[CTRL_ENABLE] = 1'b0;
        end

        compare_d = wr_compare ? wr_data : compare_q;

        count_d = count_q;
        if (wr_count) begin
            count_d = wr_data;
        end else begin
            case (tick_event)
                EV_INC:   count_d = count_q + 1'b1;
                EV_WRAP:  count_d = '0;
                EV_MATCH: count_d = ctrl_q[CTRL_AUTO_RELOAD] ? '0 : count_q;
                default:  count_d = count_q;
            endcase
        end

        // Write-one-to-clear first, hardware set last so a new event survives a clear.
        status_d = status_q;
        if (wr_status) begin
            status_d = status_q & ~wr_data[STAT_BITS-1:0];
        end
        if (tick_event == EV_MATCH) begin
            status_d[STAT_MATCH] = 1'b1;
        end
        if (tick_event == EV_WRAP) begin
            status_d[STAT_OVF] = 1'b1;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = '0;
            case (addr)
                ADDR_CTRL:    rd_data_d[CTRL_BITS-1:0] = ctrl_q;
                ADDR_COMPARE: rd_data_d = compare_q;
                ADDR_COUNT:   rd_data_d = count_q;
                ADDR_STATUS:  rd_data_d[STAT_BITS-1:0] = status_q;
                default:      rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ctrl_q    <= '0;
            compare_q <= '0;
            count_q   <= '0;
            status_q  <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            compare_q <= compare_d;
            count_q   <= count_d;
            status_q  <= status_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign irq     = status_q[STAT_MATCH] & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_timer_unit.sv
// Scoreboard bench for timer_unit: reads push expected values into a queue,
// a monitor pops and compares them the cycle rd_data becomes valid.
module tb_timer_unit;
    import timer_pkg::*;

    localparam int W = 8;

    logic         clk_in = 1'b0;
    logic         reset_n;
    logic         tick_in;
    logic         wr_en;
    logic         rd_en;
    logic [1:0]   addr;
    logic [W-1:0] wr_data;
    logic [W-1:0] rd_data;
    logic         irq;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        string       name;
        logic [31:0] value;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk_in = ~clk_in;

    timer_unit #(
        .WIDTH      (W),
        .SYNC_STAGES(2)
    ) dut (
        .clk_in (clk_in),
        .reset_n(reset_n),
        .tick_in(tick_in),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .addr   (addr),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .irq    (irq)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: rd_data is valid just after the edge that sampled rd_en.
    initial begin
        logic sampled;
        forever begin
            @(posedge clk_in);
            sampled = rd_en;
            #1;
            if (sampled) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL rd_unexpected: got 0x%0h with no expected entry", rd_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check(e.name, {{(32-W){1'b0}}, rd_data}, e.value);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "bench timeout");
    end

    task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
        @(negedge clk_in);
        wr_en   = 1'b1;
        addr    = a;
        wr_data = d;
        @(negedge clk_in);
        wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        @(negedge clk_in);
        rd_en = 1'b1;
        addr  = a;
        exp_q.push_back('{name, exp});
        @(negedge clk_in);
        rd_en = 1'b0;
    endtask

    task automatic wr_rd(input logic [1:0] a, input logic [W-1:0] d, input logic [31:0] exp,
                         input string name);
        @(negedge clk_in);
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        addr    = a;
        wr_data = d;
        exp_q.push_back('{name, exp});
        @(negedge clk_in);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    // One pre-scaler period: high for two edges, then low; the count has moved on return.
    task automatic tick();
        @(negedge clk_in);
        tick_in = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        tick_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
    endtask

    // Tick whose counting edge coincides with a register write.
    task automatic tick_with_write(input logic [1:0] a, input logic [W-1:0] d);
        @(negedge clk_in);
        tick_in = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        tick_in = 1'b0;
        @(negedge clk_in);
        wr_en   = 1'b1;
        addr    = a;
        wr_data = d;
        @(negedge clk_in);
        wr_en   = 1'b0;
    endtask

    // Tick that checks irq stays low on edge k+2 and rises on edge k+3.
    task automatic tick_irq_timing();
        @(negedge clk_in);
        tick_in = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        tick_in = 1'b0;
        @(posedge clk_in);
        #1 check("irq_before_match", {31'b0, irq}, 32'h0);
        @(posedge clk_in);
        #1 check("irq_at_match", {31'b0, irq}, 32'h1);
        @(negedge clk_in);
    endtask

    initial begin
        reset_n = 1'b0;
        tick_in = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        addr    = 2'd0;
        wr_data = '0;
        repeat (2) @(negedge clk_in);
        reset_n = 1'b1;
        @(posedge clk_in);
        #1;
        check("reset_rd_data", {24'b0, rd_data}, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        rd(ADDR_CTRL, 32'h0, "reset_ctrl");
        rd(ADDR_COMPARE, 32'h0, "reset_compare");
        rd(ADDR_COUNT, 32'h0, "reset_count");
        rd(ADDR_STATUS, 32'h0, "reset_status");
        wr(ADDR_CTRL, 8'hF8);
        rd(ADDR_CTRL, 32'h0, "ctrl_reserved_bits");

        // Auto-reload, COMPARE=3: 1,2,3,0 with match on the fourth tick.
        wr(ADDR_COMPARE, 8'd3);
        wr(ADDR_CTRL, 8'b111);
        for (int i = 1; i <= 3; i++) begin
            tick();
            rd(ADDR_COUNT, i, "auto_count");
        end
        tick_irq_timing();
        rd(ADDR_COUNT, 32'h0, "auto_count_reload");
        rd(ADDR_STATUS, 32'h1, "auto_status_match");
        wr(ADDR_STATUS, 8'h1);
        check("auto_irq_cleared", {31'b0, irq}, 32'h0);
        rd(ADDR_STATUS, 32'h0, "auto_status_cleared");
        tick();
        rd(ADDR_COUNT, 32'h1, "auto_count_restart");

        // One-shot, COMPARE=2: stops at 2, enable dropped by hardware.
        wr(ADDR_CTRL, 8'h0);
        wr(ADDR_STATUS, 8'h3);
        wr(ADDR_COUNT, 8'h0);
        wr(ADDR_COMPARE, 8'd2);
        wr(ADDR_CTRL, 8'b101);
        repeat (3) tick();
        rd(ADDR_COUNT, 32'h2, "oneshot_count");
        rd(ADDR_CTRL, 32'h4, "oneshot_ctrl");
        check("oneshot_irq", {31'b0, irq}, 32'h1);
        tick();
        rd(ADDR_COUNT, 32'h2, "oneshot_count_held");
        rd(ADDR_STATUS, 32'h1, "oneshot_status");
        wr(ADDR_STATUS, 8'h1);
        check("oneshot_irq_cleared", {31'b0, irq}, 32'h0);
        wr_rd(ADDR_COMPARE, 8'd5, 32'h2, "rd_wr_same_cycle");
        rd(ADDR_COMPARE, 32'h5, "compare_after_write");

        // Load above COMPARE: FE -> FF -> 00 (ovf) -> 1..5 -> match.
        wr(ADDR_STATUS, 8'h3);
        wr(ADDR_COUNT, 8'hFE);
        wr(ADDR_CTRL, 8'b011);
        tick();
        rd(ADDR_COUNT, 32'hFF, "ovf_count_max");
        tick();
        rd(ADDR_COUNT, 32'h0, "ovf_count_wrap");
        rd(ADDR_STATUS, 32'h2, "ovf_status");
        for (int i = 1; i <= 5; i++) begin
            tick();
            rd(ADDR_COUNT, i, "ovf_count_climb");
        end
        rd(ADDR_STATUS, 32'h2, "ovf_no_match_yet");
        tick();
        rd(ADDR_COUNT, 32'h0, "ovf_match_reload");
        rd(ADDR_STATUS, 32'h3, "ovf_then_match");

        // Same-cycle COUNT write beats the tick.
        wr(ADDR_COMPARE, 8'h40);
        wr(ADDR_COUNT, 8'h20);
        tick_with_write(ADDR_COUNT, 8'h10);
        rd(ADDR_COUNT, 32'h10, "count_write_wins");
        tick();
        rd(ADDR_COUNT, 32'h11, "count_after_load");

        // Same-cycle STATUS clear loses to a new match.
        wr(ADDR_STATUS, 8'h3);
        wr(ADDR_COUNT, 8'h40);
        tick_with_write(ADDR_STATUS, 8'h1);
        rd(ADDR_STATUS, 32'h1, "match_set_wins");
        rd(ADDR_COUNT, 32'h0, "match_set_count");

        // Same-cycle disabling CTRL write suppresses the match.
        wr(ADDR_STATUS, 8'h3);
        wr(ADDR_COUNT, 8'h40);
        tick_with_write(ADDR_CTRL, 8'h02);
        rd(ADDR_STATUS, 32'h0, "disable_beats_match");
        rd(ADDR_COUNT, 32'h40, "disable_count_held");

        // COMPARE=0 with auto-reload: every tick matches, count stays 0.
        wr(ADDR_COMPARE, 8'h0);
        wr(ADDR_COUNT, 8'h0);
        wr(ADDR_CTRL, 8'b011);
        repeat (2) tick();
        rd(ADDR_COUNT, 32'h0, "compare_zero_count");
        rd(ADDR_STATUS, 32'h1, "compare_zero_match");

        // Reset mid-count at 7, with tick_in rising across the reset edge.
        wr(ADDR_STATUS, 8'h3);
        wr(ADDR_COMPARE, 8'h40);
        wr(ADDR_COUNT, 8'h6);
        wr(ADDR_CTRL, 8'b111);
        tick();
        rd(ADDR_COUNT, 32'h7, "pre_reset_count");
        @(negedge clk_in);
        reset_n = 1'b0;
        tick_in = 1'b1;
        @(negedge clk_in);
        reset_n = 1'b1;
        check("post_reset_irq", {31'b0, irq}, 32'h0);
        check("post_reset_rd_data", {24'b0, rd_data}, 32'h0);
        @(negedge clk_in);
        @(negedge clk_in);
        tick_in = 1'b0;
        rd(ADDR_CTRL, 32'h0, "post_reset_ctrl");
        rd(ADDR_COMPARE, 32'h0, "post_reset_compare");
        rd(ADDR_COUNT, 32'h0, "post_reset_count");
        rd(ADDR_STATUS, 32'h0, "post_reset_status");
        wr(ADDR_COMPARE, 8'h40);
        wr(ADDR_CTRL, 8'b011);
        repeat (4) @(negedge clk_in);
        rd(ADDR_COUNT, 32'h0, "post_reset_tick_ignored");

        repeat (3) @(negedge clk_in);
        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
